// File: rtl/reset_sequencer.sv
// Multi-source reset controller: debounced external sources, software request and
// power-on reset feed a staged release of NUM_OUT active-high reset outputs.
module reset_sequencer #(
  parameter int unsigned NUM_SRC          = 2,
  parameter int unsigned NUM_OUT          = 3,
  parameter int unsigned POWER_ON_CYCLES  = 100,
  parameter int unsigned DEBOUNCE_CYCLES  = 10,
  parameter int unsigned RESET_MIN_CYCLES = 50,
  parameter int unsigned STAGE_DELAY      = 16,
  parameter int unsigned CNT_W            = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_n,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               sw_reset,
  input  logic               cause_clr,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic [NUM_SRC+1:0] cause
);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_REL,
    ST_SEQ,
    ST_RUN
  } state_e;

  localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POWER_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(RESET_MIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] STAGE_END  = CNT_W'(NUM_OUT - 1);

  logic [NUM_SRC-1:0] sync1_q, sync2_q;
  logic [NUM_SRC-1:0] deb_q, deb_d;
  logic [CNT_W-1:0]   deb_cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   deb_cnt_d [NUM_SRC];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   stage_q, stage_d;
  logic               por_q, por_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               busy_q, busy_d;
  logic [NUM_SRC+1:0] cause_q, cause_d;

  logic [NUM_SRC-1:0] req_vec;
  logic               req;
  logic               trig;
  logic [CNT_W-1:0]   hold_last;
  logic [CNT_W-1:0]   stage_nxt;

  // Debounce: deb_q rises once the synchronized input has been low DEBOUNCE_CYCLES cycles.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      deb_d[i]     = 1'b0;
      if (sync2_q[i]) begin
        deb_cnt_d[i] = '0;
      end else begin
        if (deb_cnt_q[i] != DEB_LAST) deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        deb_d[i] = (deb_cnt_q[i] == DEB_LAST);
      end
    end
  end

  always_comb begin
    req_vec = deb_q & src_mask;
    req     = |req_vec;
    trig    = req | sw_reset;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= src_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int unsigned i = 0; i < NUM_SRC; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // State register (registered outputs live alongside so no input reaches an output combinationally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      stage_q   <= '0;
      por_q     <= 1'b1;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      cause_q   <= (NUM_SRC + 2)'(1);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      por_q     <= por_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    por_d     = por_q;
    hold_last = por_q ? POR_LAST : MIN_LAST;
    stage_nxt = stage_q + 1'b1;
    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == hold_last) begin
          cnt_d   = '0;
          por_d   = 1'b0;
          state_d = ST_WAIT_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (!req) begin
          cnt_d   = '0;
          stage_d = '0;
          state_d = (NUM_OUT == 1) ? ST_RUN : ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (trig) begin
          cnt_d   = '0;
          state_d = ST_ASSERT;
        end else if (cnt_q == STAGE_LAST) begin
          cnt_d   = '0;
          stage_d = stage_nxt;
          if (stage_nxt == STAGE_END) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (trig) begin
          cnt_d   = '0;
          state_d = ST_ASSERT;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_ASSERT;
      end
    endcase
  end

  // Outputs derived from the next state: in SEQ, stage k means bits 0..k are released.
  always_comb begin
    rst_out_d = '1;
    for (int unsigned j = 0; j < NUM_OUT; j++) begin
      case (state_d)
        ST_SEQ:  rst_out_d[j] = (CNT_W'(j) > stage_d);
        ST_RUN:  rst_out_d[j] = 1'b0;
        default: rst_out_d[j] = 1'b1;
      endcase
    end
    busy_d  = |rst_out_d;
    cause_d = (cause_clr ? '0 : cause_q) | {req_vec, sw_reset, 1'b0};
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus randomized
// stimulus compared every cycle against a timeline-based reference model.
module tb_reset_sequencer;

  localparam int NUM_SRC = 2;
  localparam int NUM_OUT = 3;
  localparam int POR     = 100;
  localparam int DEB     = 10;
  localparam int RMIN    = 50;
  localparam int SD      = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_SRC-1:0] src_n = '1;
  logic [NUM_SRC-1:0] src_mask = '1;
  logic               sw_reset = 1'b0;
  logic               cause_clr = 1'b0;
  logic [NUM_OUT-1:0] rst_out;
  logic               busy;
  logic [NUM_SRC+1:0] cause;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_SRC(NUM_SRC), .NUM_OUT(NUM_OUT), .POWER_ON_CYCLES(POR),
    .DEBOUNCE_CYCLES(DEB), .RESET_MIN_CYCLES(RMIN), .STAGE_DELAY(SD), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_n(src_n), .src_mask(src_mask),
    .sw_reset(sw_reset), .cause_clr(cause_clr),
    .rst_out(rst_out), .busy(busy), .cause(cause)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: time since the reset began holding, and time since stage 0 released.
  bit                 m_rel;
  int                 m_elapsed, m_target, m_age;
  logic [NUM_SRC+1:0] m_cause;
  int                 lr_now [NUM_SRC];
  int                 lr_d1  [NUM_SRC];
  int                 lr_d2  [NUM_SRC];

  function automatic logic [NUM_OUT-1:0] m_rst_out();
    logic [NUM_OUT-1:0] r;
    for (int j = 0; j < NUM_OUT; j++) r[j] = !m_rel || (m_age < j * SD);
    return r;
  endfunction

  task automatic model_reset();
    m_rel = 1'b0; m_elapsed = 0; m_target = POR; m_age = 0;
    m_cause = (NUM_SRC + 2)'(1);
    for (int i = 0; i < NUM_SRC; i++) begin lr_now[i] = 0; lr_d1[i] = 0; lr_d2[i] = 0; end
  endtask

  task automatic model_edge();
    logic [NUM_SRC-1:0] deb;
    logic [NUM_SRC-1:0] act;
    bit req;
    // A source counts once it was sampled low DEB times in a row, seen through two sync stages.
    for (int i = 0; i < NUM_SRC; i++) deb[i] = (lr_d2[i] >= DEB);
    act = deb & src_mask;
    req = |act;
    m_cause = (cause_clr ? '0 : m_cause) | {act, sw_reset, 1'b0};
    if (!m_rel) begin
      if (m_elapsed < m_target) m_elapsed++;
      else if (!req) begin m_rel = 1'b1; m_age = 0; end
    end else if (req || sw_reset) begin
      m_rel = 1'b0; m_elapsed = 0; m_target = RMIN;
    end else if (m_age < 100000) begin
      m_age++;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      lr_d2[i] = lr_d1[i];
      lr_d1[i] = lr_now[i];
      lr_now[i] = src_n[i] ? 0 : ((lr_now[i] < 100000) ? lr_now[i] + 1 : lr_now[i]);
    end
  endtask

  task automatic tick();
    logic [NUM_OUT-1:0] e;
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    @(negedge clk);
    e = m_rst_out();
    check_eq("rst_out", 32'(rst_out), 32'(e));
    check_eq("busy", 32'(busy), 32'(|e));
    check_eq("cause", 32'(cause), 32'(m_cause));
  endtask

  task automatic wait_rst0_low(input string tag);
    int n = 0;
    while (rst_out[0] !== 1'b0 && n < 400) begin tick(); n++; end
    check_eq(tag, 32'(n < 400), 32'd1);
  endtask

  initial begin
    int lat;
    model_reset();
    repeat (3) tick();
    check_eq("reset_rst_out", 32'(rst_out), 32'h7);
    check_eq("reset_cause", 32'(cause), 32'h1);

    // Power-on release and staged sequence
    rst_n = 1'b1;
    repeat (160) tick();
    check_eq("por_done_rst_out", 32'(rst_out), 32'h0);
    check_eq("por_done_cause", 32'(cause), 32'h1);

    // Glitch one cycle short of the debounce length
    src_n[0] = 1'b0;
    repeat (DEB - 1) tick();
    src_n[0] = 1'b1;
    repeat (20) tick();
    check_eq("glitch_rst_out", 32'(rst_out), 32'h0);
    check_eq("glitch_cause", 32'(cause), 32'h1);

    // Held source: latency, hold, cause
    cause_clr = 1'b1; tick(); cause_clr = 1'b0;
    src_n[1] = 1'b0;
    lat = 0;
    while (rst_out !== 3'b111 && lat < 40) begin tick(); lat++; end
    check_eq("src_latency", 32'(lat), 32'(2 + DEB + 1));
    repeat (200 - lat) tick();
    check_eq("src_held_rst_out", 32'(rst_out), 32'h7);
    src_n[1] = 1'b1;
    repeat (120) tick();
    check_eq("src_cause", 32'(cause), 32'h8);

    // Masked source ignored; software reset still works
    src_mask = 2'b10;
    src_n[0] = 1'b0;
    repeat (100) tick();
    check_eq("mask_rst_out", 32'(rst_out), 32'h0);
    sw_reset = 1'b1; tick(); sw_reset = 1'b0;
    check_eq("sw_rst_out", 32'(rst_out), 32'h7);
    repeat (100) tick();
    check_eq("sw_cause_bit", 32'(cause[1]), 32'd1);
    src_n[0] = 1'b1;
    repeat (20) tick();
    src_mask = 2'b11;
    repeat (5) tick();

    // Abort mid-sequence
    sw_reset = 1'b1; tick(); sw_reset = 1'b0;
    wait_rst0_low("abort_wait_timeout");
    repeat (4) tick();
    sw_reset = 1'b1; tick(); sw_reset = 1'b0;
    check_eq("abort_rst_out", 32'(rst_out), 32'h7);
    repeat (150) tick();

    // cause_clr together with sw_reset, then async reset during SEQ
    cause_clr = 1'b1; sw_reset = 1'b1; tick(); cause_clr = 1'b0; sw_reset = 1'b0;
    check_eq("clr_sw_cause", 32'(cause), 32'h2);
    wait_rst0_low("async_wait_timeout");
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_out", 32'(rst_out), 32'h7);
    check_eq("async_busy", 32'(busy), 32'd1);
    check_eq("async_cause", 32'(cause), 32'h1);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (150) tick();

    // Randomized stimulus against the model
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      for (int i = 0; i < NUM_SRC; i++) src_n[i] = ($urandom_range(0, 3) != 0);
      src_mask = NUM_SRC'($urandom);
      len = $urandom_range(1, 60);
      for (int c = 0; c < len; c++) begin
        sw_reset  = ($urandom_range(0, 49) == 0);
        cause_clr = ($urandom_range(0, 29) == 0);
        tick();
      end
      sw_reset = 1'b0; cause_clr = 1'b0;
    end
    src_n = '1;
    repeat (200) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
